// File: rtl/sram_arbiter.sv
// Arbiter for the single asynchronous SRAM port: serves the data load/store first,
// then the instruction fetch, sequencing ce/oe/we strobes with a registered FSM.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 20
) (
  input  logic               main_clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic [31:0]        pc,
  output logic [31:0]        instr_read,
  input  logic               data_write_en,
  input  logic               is_data_read,
  input  logic               mem_byte_en,
  input  logic               mem_sign_ext,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_write,
  output logic [31:0]        data_read,
  output logic               mem_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA_RD  = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    INST_RD  = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(ACCESS_CYCLES - 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 fetch_q;
  logic                 byte_q;
  logic                 sign_q;
  logic [1:0]           lane_q;
  logic [SRAM_AW-1:0]   pc_addr_q;

  logic                 any_req;
  logic [3:0]           req_be_n;
  logic [31:0]          req_wdata;
  logic [7:0]           lane_byte;
  logic [31:0]          load_value;
  logic                 unused_bits;

  assign unused_bits = ^{pc[31:SRAM_AW+2], pc[1:0], data_addr[31:SRAM_AW+2]};

  always_comb begin
    any_req    = inst_req | data_write_en | is_data_read;
    req_be_n   = mem_byte_en ? ~(4'b0001 << data_addr[1:0]) : 4'h0;
    req_wdata  = mem_byte_en ? {4{data_write[7:0]}} : data_write;
    lane_byte  = sram_rdata[8*lane_q +: 8];
    load_value = sram_rdata;
    if (byte_q) begin
      load_value = sign_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
    end
  end

  // Handshake: the core presents a request bundle and holds it while mem_stall=1;
  // mem_stall drops in DONE, the core advances on that edge, and the next bundle
  // is sampled in the following IDLE cycle.
  assign mem_stall = (state_q == IDLE && any_req) ||
                     (state_q inside {DATA_RD, WR_SETUP, WR_PULSE, WR_HOLD, INST_RD});

  assign dbg_state_o = state_q;

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fetch_q    <= 1'b0;
      byte_q     <= 1'b0;
      sign_q     <= 1'b0;
      lane_q     <= 2'b00;
      pc_addr_q  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_addr  <= '0;
      sram_wdata <= '0;
      instr_read <= '0;
      data_read  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          fetch_q   <= inst_req;
          byte_q    <= mem_byte_en;
          sign_q    <= mem_sign_ext;
          lane_q    <= data_addr[1:0];
          pc_addr_q <= pc[SRAM_AW+1:2];
          // A store takes priority; a simultaneous load is dropped.
          if (data_write_en) begin
            state_q    <= WR_SETUP;
            sram_ce_n  <= 1'b0;
            sram_addr  <= data_addr[SRAM_AW+1:2];
            sram_wdata <= req_wdata;
            sram_be_n  <= req_be_n;
          end else if (is_data_read) begin
            state_q   <= DATA_RD;
            cnt_q     <= CNT_RELOAD;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_addr <= data_addr[SRAM_AW+1:2];
            sram_be_n <= req_be_n;
          end else if (inst_req) begin
            state_q   <= INST_RD;
            cnt_q     <= CNT_RELOAD;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_addr <= pc[SRAM_AW+1:2];
            sram_be_n <= 4'h0;
          end
        end
        DATA_RD: begin
          if (cnt_q == '0) begin
            data_read <= load_value;
            if (fetch_q) begin
              state_q   <= INST_RD;
              cnt_q     <= CNT_RELOAD;
              sram_addr <= pc_addr_q;
              sram_be_n <= 4'h0;
            end else begin
              state_q   <= DONE;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_be_n <= 4'hF;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WR_SETUP: begin
          state_q   <= WR_PULSE;
          cnt_q     <= CNT_RELOAD;
          sram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt_q == '0) begin
            state_q   <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WR_HOLD: begin
          if (fetch_q) begin
            state_q   <= INST_RD;
            cnt_q     <= CNT_RELOAD;
            sram_oe_n <= 1'b0;
            sram_addr <= pc_addr_q;
            sram_be_n <= 4'h0;
          end else begin
            state_q   <= DONE;
            sram_ce_n <= 1'b1;
            sram_be_n <= 4'hF;
          end
        end
        INST_RD: begin
          if (cnt_q == '0) begin
            instr_read <= sram_rdata;
            state_q    <= DONE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_be_n  <= 4'hF;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 32-bit asynchronous SRAM port between the CPU instruction-fetch path (pc) and the data load/store path (mem_ctrl_signal bundle).
- Sequences the SRAM strobes with a multi-cycle FSM and holds the core with mem_stall until every request of the current cycle has completed.
- Sits between cpu_core and the board SRAM pins, on main_clk.
- Data access is served before instruction fetch.

Parameters:
- ACCESS_CYCLES, 2, cycles each read strobe and write pulse is held (>=1)
- SRAM_AW, 20, SRAM word-address width

Ports:
- main_clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request for current cycle
- pc  in  32  fetch byte address
- instr_read  out  32  fetched instruction (registered)
- data_write_en  in  1  store request
- is_data_read  in  1  load request
- mem_byte_en  in  1  1=byte access, 0=word access
- mem_sign_ext  in  1  byte load: 1=sign-extend, 0=zero-extend
- data_addr  in  32  data byte address
- data_write  in  32  store data
- data_read  out  32  load result (registered)
- mem_stall  out  1  hold the core pipeline
- sram_addr  out  SRAM_AW  word address
- sram_wdata  out  32  write data to pins
- sram_rdata  in  32  read data from pins
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
- sram_be_n  out  4  active-low byte enables

Behaviour:
- Reset (async, immediate): state=IDLE; all strobes=1; sram_be_n=4'hF; sram_addr=0; sram_wdata=0; instr_read=0; data_read=0; mem_stall=0. A reset mid-access drops strobes in the same instant; the access is abandoned.
- Request bundle, sampled in IDLE: data op = store if data_write_en, else load if is_data_read. If both are set, the store wins and the load is ignored. Fetch if inst_req.
- States: IDLE, DATA_RD, WR_SETUP, WR_PULSE, WR_HOLD, INST_RD, DONE.
- IDLE:
  - store -> WR_SETUP; load -> DATA_RD; fetch only -> INST_RD; nothing -> IDLE.
  - Request fields are latched at this edge and held through the bundle.
- DATA_RD, ACCESS_CYCLES cycles:
  - ce_n=0, oe_n=0, we_n=1, sram_addr=data_addr[SRAM_AW+1:2].
  - data_read captured at the last cycle's edge.
  - Then -> INST_RD if fetch latched, else DONE.
- Store sequence:
  - WR_SETUP, 1 cycle: ce_n=0, we_n=1, addr, wdata and be_n driven.
  - WR_PULSE, ACCESS_CYCLES cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, addr and data held.
  - Then -> INST_RD if fetch latched, else DONE.
- INST_RD, ACCESS_CYCLES cycles: read at pc[SRAM_AW+1:2] with sram_be_n=0; instr_read captured at the last edge; -> DONE.
- DONE, 1 cycle: strobes inactive; -> IDLE.
- mem_stall (combinational):
  - 1 when (state==IDLE and any request) or state in {DATA_RD, WR_*, INST_RD}.
  - 0 in DONE and in IDLE with no request.
  - The core advances on the DONE edge; the next bundle is seen in the following IDLE.
- Byte/word rules:
  - Word access: be_n=4'h0; address bits [1:0] ignored, with no misalignment flag.
  - Byte access: lane L=data_addr[1:0]; be_n has only bit L low.
  - Byte store: data_write[7:0] replicated to all four lanes.
  - Byte load: lane L extracted, then sign- or zero-extended to 32 bits per mem_sign_ext.
- Counter: one down-counter reloaded with ACCESS_CYCLES-1 on entry to DATA_RD, WR_PULSE and INST_RD; the state exits when the counter is 0. ACCESS_CYCLES=1 gives single-cycle phases.
- Latency with ACCESS_CYCLES=2 (stall cycles before DONE):
  - fetch only 3
  - load+fetch 5
  - store+fetch 7
  - store only 5
- Strobes are registered outputs, glitch-free.
- instr_read and data_read hold their last value until recaptured.

Test Plan:
- Reset mid-WR_PULSE (assert rst with we_n=0) -> we_n and ce_n go to 1 before the next edge; state IDLE; mem_stall=0.
- Fetch only, pc=0x80000004, sram_rdata=0x3402_0001 -> sram_addr=0x00001; stall for 3 cycles; DONE with instr_read=0x34020001, stall=0.
- Load word + fetch, data_addr=0x80000100, SRAM returns 0xDEADBEEF -> DATA_RD at addr 0x40 with be_n=0, then INST_RD; data_read=0xDEADBEEF; stall for 5 cycles.
- Byte load, data_addr[1:0]=3, sram_rdata=0x80xx_xxxx:
  - mem_sign_ext=1 -> data_read=0xFFFFFF80
  - mem_sign_ext=0 -> data_read=0x00000080
- Byte store, data_addr[1:0]=1, data_write=0x000000A5 -> sram_wdata=0xA5A5A5A5; be_n=4'b1101; we_n low exactly 2 cycles; setup and hold 1 cycle each.
- data_write_en=1 and is_data_read=1 together -> store only; data_read unchanged; no DATA_RD state visited.
